// File: rtl/mix_muldiv.sv
// mix_muldiv: multi-cycle sign-magnitude MUL/DIV unit for the MIX core.
//   MUL (op=0): {out_a,out_x} = a * v, both halves carry sign(a)^sign(v).
//   DIV (op=1): {|a|,x[W-1:0]} / |v| -> out_a = quotient (sign sa^sv),
//               out_x = remainder (sign sa). |a| >= |v| flags overflow and
//               returns a and x unchanged with no iteration cycles.
// Ports:
//   clk, reset_n     clock, asynchronous active-low reset
//   start, op        one-cycle request (sampled in IDLE only), 0=MUL 1=DIV
//   a, x, v          W+1-bit operands, bit W is the sign
//   busy, stop       ITER/DONE indicator, one-cycle completion pulse
//   out_a, out_x     results, held until the next accepted start
//   overflow         DIV overflow flag
// Build option: define MIX_MULDIV_RADIX4_EN to retire two steps per cycle.
module mix_muldiv #(
  parameter int unsigned BYTE_BITS = 6,
  parameter int unsigned BYTES     = 5
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          start,
  input  logic                          op,
  input  logic [BYTES*BYTE_BITS:0]      a,
  input  logic [BYTES*BYTE_BITS:0]      x,
  input  logic [BYTES*BYTE_BITS:0]      v,
  output logic                          busy,
  output logic                          stop,
  output logic [BYTES*BYTE_BITS:0]      out_a,
  output logic [BYTES*BYTE_BITS:0]      out_x,
  output logic                          overflow
);

  localparam int unsigned W  = BYTES * BYTE_BITS;
`ifdef MIX_MULDIV_RADIX4_EN
  localparam int unsigned K  = W / 2;
`else
  localparam int unsigned K  = W;
`endif
  localparam int unsigned CW = $clog2(K + 1);

  typedef enum logic [1:0] {S_IDLE, S_ITER, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [2*W-1:0]   acc_q, acc_d;
  logic [W-1:0]     vmag_q, vmag_d;
  logic             op_q, op_d;
  logic             sa_q, sa_d;
  logic             sres_q, sres_d;
  logic [W:0]       out_a_q, out_a_d;
  logic [W:0]       out_x_q, out_x_d;
  logic             ovf_q, ovf_d;

  logic [W-1:0]     amag;
  logic [W-1:0]     vmag_in;
  logic [2*W-1:0]   acc_step;

  // One radix-2 step. MUL: acc = {partial product high, multiplier}, shifted
  // right after the conditional add. DIV: acc = {remainder, dividend low /
  // quotient}, shifted left with the quotient bit entering at the bottom.
  function automatic logic [2*W-1:0] step_f(input logic [2*W-1:0] acc,
                                            input logic           is_div,
                                            input logic [W-1:0]   vm);
    logic [W:0] sum;
    logic [W:0] tmp;
    logic [W:0] diff;
    logic       qbit;
    sum  = '0;
    tmp  = '0;
    diff = '0;
    qbit = 1'b0;
    if (is_div) begin
      tmp  = {acc[2*W-1:W], acc[W-1]};
      diff = tmp - {1'b0, vm};
      if (tmp >= {1'b0, vm}) begin
        qbit = 1'b1;
      end else begin
        diff = tmp;
      end
      // Remainder stays below |v| so it always fits in W bits.
      step_f = {diff[W-1:0], acc[W-2:0], qbit};
    end else begin
      sum    = {1'b0, acc[2*W-1:W]} + (acc[0] ? {1'b0, vm} : (W+1)'(0));
      step_f = {sum, acc[W-1:1]};
    end
  endfunction

  assign amag    = a[W-1:0];
  assign vmag_in = v[W-1:0];

`ifdef MIX_MULDIV_RADIX4_EN
  assign acc_step = step_f(step_f(acc_q, op_q, vmag_q), op_q, vmag_q);
`else
  assign acc_step = step_f(acc_q, op_q, vmag_q);
`endif

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      vmag_q  <= '0;
      op_q    <= 1'b0;
      sa_q    <= 1'b0;
      sres_q  <= 1'b0;
      out_a_q <= '0;
      out_x_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      vmag_q  <= vmag_d;
      op_q    <= op_d;
      sa_q    <= sa_d;
      sres_q  <= sres_d;
      out_a_q <= out_a_d;
      out_x_q <= out_x_d;
      ovf_q   <= ovf_d;
    end
  end

  // Next-state and result logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    vmag_d  = vmag_q;
    op_d    = op_q;
    sa_d    = sa_q;
    sres_d  = sres_q;
    out_a_d = out_a_q;
    out_x_d = out_x_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          op_d   = op;
          sa_d   = a[W];
          sres_d = a[W] ^ v[W];
          vmag_d = vmag_in;
          if (op && (amag >= vmag_in)) begin
            // Quotient would not fit (includes divide by +/-0).
            out_a_d = a;
            out_x_d = x;
            ovf_d   = 1'b1;
            state_d = S_DONE;
          end else begin
            acc_d   = op ? {amag, x[W-1:0]} : {W'(0), amag};
            cnt_d   = CW'(K);
            ovf_d   = 1'b0;
            state_d = S_ITER;
          end
        end
      end
      S_ITER: begin
        acc_d = acc_step;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          out_a_d = {sres_q, acc_step[2*W-1:W]};
          out_x_d = {op_q ? sa_q : sres_q, acc_step[W-1:0]};
          if (op_q) begin
            // Division: quotient in the low half, remainder in the high half.
            out_a_d = {sres_q, acc_step[W-1:0]};
            out_x_d = {sa_q, acc_step[2*W-1:W]};
          end
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign busy     = (state_q != S_IDLE);
  assign stop     = (state_q == S_DONE);
  assign out_a    = out_a_q;
  assign out_x    = out_x_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_mix_muldiv.sv
// Directed self-checking bench for mix_muldiv at default parameters.
module tb_mix_muldiv;

  localparam int W = 30;
`ifdef MIX_MULDIV_RADIX4_EN
  localparam int K = W / 2;
`else
  localparam int K = W;
`endif
  localparam int TMO = 400;

  typedef logic [W:0] word_t;

  logic  clk = 1'b0;
  logic  reset_n;
  logic  start;
  logic  op;
  word_t a, x, v;
  logic  busy, stop, overflow;
  word_t out_a, out_x;

  int checks = 0;
  int errors = 0;

  mix_muldiv dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .start    (start),
    .op       (op),
    .a        (a),
    .x        (x),
    .v        (v),
    .busy     (busy),
    .stop     (stop),
    .out_a    (out_a),
    .out_x    (out_x),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  // Launch one operation (start edge = edge 0) and count edges until stop.
  task automatic run_op(input logic o, input word_t ai, input word_t xi,
                        input word_t vi, output int lat);
    @(negedge clk);
    start = 1'b1; op = o; a = ai; x = xi; v = vi;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0;
    while (stop !== 1'b1 && lat < TMO) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic test_reset;
    reset_n = 1'b0; start = 1'b0; op = 1'b0; a = '0; x = '0; v = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    checks++; if (stop !== 1'b0) begin errors++; $display("FAIL reset_stop got %b exp 0", stop); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b exp 0", overflow); end
    checks++; if (out_a !== '0) begin errors++; $display("FAIL reset_out_a got %h exp 0", out_a); end
    checks++; if (out_x !== '0) begin errors++; $display("FAIL reset_out_x got %h exp 0", out_x); end
    @(negedge clk); reset_n = 1'b1;
  endtask

  task automatic test_mul;
    int    lat;
    word_t ea, ex;
    // +2 * -3 = -6 : high half is -0
    run_op(1'b0, {1'b0, 30'd2}, '0, {1'b1, 30'd3}, lat);
    checks++; if (lat !== K) begin errors++; $display("FAIL mul_latency got %0d exp %0d", lat, K); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mul_busy_at_stop got %b exp 1", busy); end
    ea = {1'b1, 30'd0}; ex = {1'b1, 30'd6};
    checks++; if (out_a !== ea) begin errors++; $display("FAIL mul_small_a got %h exp %h", out_a, ea); end
    checks++; if (out_x !== ex) begin errors++; $display("FAIL mul_small_x got %h exp %h", out_x, ex); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL mul_small_ovf got %b exp 0", overflow); end
    @(posedge clk); #1;
    checks++; if (stop !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL mul_idle got stop=%b busy=%b exp 0 0", stop, busy); end
    // (2^30-1)^2 = (2^30-2)*2^30 + 1
    run_op(1'b0, {1'b0, 30'h3FFF_FFFF}, '0, {1'b0, 30'h3FFF_FFFF}, lat);
    ea = {1'b0, 30'h3FFF_FFFE}; ex = {1'b0, 30'd1};
    checks++; if (out_a !== ea) begin errors++; $display("FAIL mul_max_a got %h exp %h", out_a, ea); end
    checks++; if (out_x !== ex) begin errors++; $display("FAIL mul_max_x got %h exp %h", out_x, ex); end
    @(posedge clk); #1;
  endtask

  task automatic test_div;
    int    lat;
    word_t ea, ex;
    // 17 / 5 = 3 rem 2
    run_op(1'b1, {1'b0, 30'd0}, {1'b0, 30'd17}, {1'b0, 30'd5}, lat);
    ea = {1'b0, 30'd3}; ex = {1'b0, 30'd2};
    checks++; if (lat !== K) begin errors++; $display("FAIL div_latency got %0d exp %0d", lat, K); end
    checks++; if (out_a !== ea) begin errors++; $display("FAIL div_pos_a got %h exp %h", out_a, ea); end
    checks++; if (out_x !== ex) begin errors++; $display("FAIL div_pos_x got %h exp %h", out_x, ex); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL div_pos_ovf got %b exp 0", overflow); end
    @(posedge clk); #1;
    // a = -0 flips both signs
    run_op(1'b1, {1'b1, 30'd0}, {1'b0, 30'd17}, {1'b0, 30'd5}, lat);
    ea = {1'b1, 30'd3}; ex = {1'b1, 30'd2};
    checks++; if (out_a !== ea) begin errors++; $display("FAIL div_neg_a got %h exp %h", out_a, ea); end
    checks++; if (out_x !== ex) begin errors++; $display("FAIL div_neg_x got %h exp %h", out_x, ex); end
    @(posedge clk); #1;
  endtask

  task automatic test_div_overflow;
    int    lat;
    word_t ea, ex;
    ea = {1'b0, 30'd5}; ex = {1'b0, 30'd0};
    run_op(1'b1, ea, ex, {1'b0, 30'd5}, lat);
    checks++; if (lat !== 0) begin errors++; $display("FAIL ovf_latency got %0d exp 0", lat); end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag got %b exp 1", overflow); end
    checks++; if (out_a !== ea) begin errors++; $display("FAIL ovf_a got %h exp %h", out_a, ea); end
    checks++; if (out_x !== ex) begin errors++; $display("FAIL ovf_x got %h exp %h", out_x, ex); end
    @(posedge clk); #1;
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_hold got %b exp 1", overflow); end
    // divide by -0
    ea = {1'b1, 30'd9}; ex = {1'b0, 30'd4};
    run_op(1'b1, ea, ex, {1'b1, 30'd0}, lat);
    checks++; if (lat !== 0) begin errors++; $display("FAIL ovf0_latency got %0d exp 0", lat); end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf0_flag got %b exp 1", overflow); end
    checks++; if (out_a !== ea || out_x !== ex) begin errors++; $display("FAIL ovf0_pass got %h %h exp %h %h", out_a, out_x, ea, ex); end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back;
    int    cyc;
    int    nstop;
    int    first_at;
    int    second_at;
    word_t r1, r2;
    @(negedge clk);
    start = 1'b1; op = 1'b0; a = {1'b0, 30'd3}; x = '0; v = {1'b0, 30'd4};
    @(posedge clk); #1;
    cyc = 0; nstop = 0; first_at = -1; second_at = -1; r1 = '0; r2 = '0;
    while (nstop < 2 && cyc < TMO) begin
      @(posedge clk); #1;
      cyc++;
      if (cyc == 10) begin
        // New operands while busy, start still high.
        a = {1'b0, 30'd7}; v = {1'b1, 30'd6};
      end
      if (stop === 1'b1) begin
        nstop++;
        if (nstop == 1) begin first_at = cyc; r1 = out_x; end
        else begin second_at = cyc; r2 = out_x; start = 1'b0; end
      end
    end
    checks++; if (first_at !== K) begin errors++; $display("FAIL b2b_first_stop got %0d exp %0d", first_at, K); end
    checks++; if (r1 !== {1'b0, 30'd12}) begin errors++; $display("FAIL b2b_first_x got %h exp %h", r1, {1'b0, 30'd12}); end
    checks++; if (r2 !== {1'b1, 30'd42}) begin errors++; $display("FAIL b2b_second_x got %h exp %h", r2, {1'b1, 30'd42}); end
    checks++; if (second_at - first_at < K + 1) begin errors++; $display("FAIL b2b_gap got %0d exp >= %0d", second_at - first_at, K + 1); end
    nstop = 0;
    repeat (2 * K + 4) begin
      @(posedge clk); #1;
      if (stop === 1'b1) nstop++;
    end
    checks++; if (nstop !== 0) begin errors++; $display("FAIL b2b_extra_stop got %0d exp 0", nstop); end
  endtask

  task automatic test_reset_mid;
    int lat;
    int nstop;
    @(negedge clk);
    start = 1'b1; op = 1'b1; a = {1'b0, 30'd0}; x = {1'b0, 30'd17}; v = {1'b0, 30'd5};
    @(posedge clk); #1;
    start = 1'b0;
    repeat (12) @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    checks++; if (out_a !== '0 || out_x !== '0) begin errors++; $display("FAIL mid_reset_out got %h %h exp 0 0", out_a, out_x); end
    checks++; if (busy !== 1'b0 || stop !== 1'b0 || overflow !== 1'b0) begin errors++; $display("FAIL mid_reset_ctl got %b%b%b exp 000", busy, stop, overflow); end
    nstop = 0;
    repeat (2) begin @(posedge clk); #1; if (stop === 1'b1) nstop++; end
    @(negedge clk); reset_n = 1'b1;
    repeat (K + 5) begin @(posedge clk); #1; if (stop === 1'b1) nstop++; end
    checks++; if (nstop !== 0) begin errors++; $display("FAIL mid_reset_stop got %0d exp 0", nstop); end
    run_op(1'b0, {1'b0, 30'd2}, '0, {1'b1, 30'd3}, lat);
    checks++; if (lat !== K) begin errors++; $display("FAIL post_reset_latency got %0d exp %0d", lat, K); end
    checks++; if (out_x !== {1'b1, 30'd6}) begin errors++; $display("FAIL post_reset_x got %h exp %h", out_x, {1'b1, 30'd6}); end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_mul();
    test_div();
    test_div_overflow();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
